// File: rtl/rr_arb8_dec.sv
// Round-robin arbiter for 8 requesters with a bounded hold time.
// The grant is held as a 3-bit index and decoded to a registered one-hot select.
module rr_arb8_dec #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       tmo,
  output logic [0:0] state_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_vld_q, gnt_vld_d;
  logic       tmo_q, tmo_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] last_idx_q, last_idx_d;

  logic       found;
  logic [2:0] win_idx;
  logic [2:0] cand;

  // Circular search starting just after the last served index, so the
  // previous owner is always considered last.
  always_comb begin
    found   = 1'b0;
    win_idx = 3'd0;
    cand    = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_idx_q + 3'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    tmo_d      = 1'b0;
    hold_cnt_d = hold_cnt_q;
    last_idx_d = last_idx_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          gnt_idx_d  = win_idx;
          gnt_d      = 8'd1 << win_idx;
          gnt_vld_d  = 1'b1;
          hold_cnt_d = 8'd1;
        end
      end
      GRANT: begin
        if (!req[gnt_idx_q]) begin
          state_d    = IDLE;
          gnt_d      = 8'd0;
          gnt_vld_d  = 1'b0;
          last_idx_d = gnt_idx_q;
          hold_cnt_d = 8'd0;
        end else if (hold_cnt_q == 8'(MAX_HOLD)) begin
          state_d    = IDLE;
          gnt_d      = 8'd0;
          gnt_vld_d  = 1'b0;
          tmo_d      = 1'b1;
          last_idx_d = gnt_idx_q;
          hold_cnt_d = 8'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = 8'd0;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // last_idx resets to 7 so the first search after reset begins at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 8'd0;
      gnt_idx_q  <= 3'd0;
      gnt_vld_q  <= 1'b0;
      tmo_q      <= 1'b0;
      hold_cnt_q <= 8'd0;
      last_idx_q <= 3'd7;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      tmo_q      <= tmo_d;
      hold_cnt_q <= hold_cnt_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign tmo     = tmo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_rr_arb8_dec.sv
// Table-driven bench for rr_arb8_dec plus directed sequences for timeout
// and asynchronous reset.
module tb_rr_arb8_dec;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;
  logic [0:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic inv_en = 1'b0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       tmo;
  } vec_t;

  vec_t vecs[$];

  rr_arb8_dec #(.MAX_HOLD(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_out(input string name, input logic [7:0] eg, input logic [2:0] ei,
                           input logic ev, input logic et);
    check({name, ".gnt"}, 32'(gnt), 32'(eg));
    check({name, ".vld"}, 32'(gnt_vld), 32'(ev));
    check({name, ".tmo"}, 32'(tmo), 32'(et));
    if (ev) check({name, ".idx"}, 32'(gnt_idx), 32'(ei));
  endtask

  // driver: called at a negedge, applies req, returns at the following negedge
  task automatic step(input logic [7:0] r);
    req = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] r, input logic [7:0] g, input logic [2:0] i,
                      input logic v, input logic t);
    vec_t e;
    e.req = r; e.gnt = g; e.idx = i; e.vld = v; e.tmo = t;
    vecs.push_back(e);
  endtask

  // invariants sampled every cycle once the design is out of its first reset
  always @(negedge clk) begin
    if (inv_en) begin
      check("inv_gnt_decode", 32'(gnt), gnt_vld ? 32'(8'd1 << gnt_idx) : 32'd0);
      check("inv_tmo_vs_vld", 32'(tmo & gnt_vld), 32'd0);
    end
  end

  initial begin
    // rotation: every winner holds two cycles, drops, then re-requests
    for (int i = 0; i < 8; i++) begin
      push(8'hFF, 8'(1 << i), 3'(i), 1'b1, 1'b0);
      push(8'hFF, 8'(1 << i), 3'(i), 1'b1, 1'b0);
      push(8'hFF & ~8'(1 << i), 8'h00, 3'd0, 1'b0, 1'b0);
    end
    push(8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);
    // priority after release: 3 served, then 0 wins over re-requesting 3
    push(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    push(8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
    push(8'h09, 8'h08, 3'd3, 1'b1, 1'b0);
    push(8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    push(8'h09, 8'h01, 3'd0, 1'b1, 1'b0);
    push(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    // glitch immunity on a grant to 2
    push(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
    push(8'hFC, 8'h04, 3'd2, 1'b1, 1'b0);
    push(8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
    push(8'hFC, 8'h04, 3'd2, 1'b1, 1'b0);
    push(8'hA4, 8'h04, 3'd2, 1'b1, 1'b0);
    push(8'h5C, 8'h04, 3'd2, 1'b1, 1'b0);
    push(8'hF8, 8'h00, 3'd0, 1'b0, 1'b0);
    push(8'hF8, 8'h08, 3'd3, 1'b1, 1'b0);
    push(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    // reset with all requests active
    rst_n = 1'b1;
    req   = 8'hFF;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(8'hFF);
    check_out("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);
    inv_en = 1'b1;

    do_reset();
    foreach (vecs[n]) begin
      step(vecs[n].req);
      check_out($sformatf("vec%0d", n), vecs[n].gnt, vecs[n].idx, vecs[n].vld, vecs[n].tmo);
    end

    // single requester held: 16 grant cycles, one tmo gap, then regranted
    for (int c = 1; c <= 16; c++) begin
      step(8'h20);
      check_out($sformatf("hold%0d", c), 8'h20, 3'd5, 1'b1, 1'b0);
    end
    step(8'h20);
    check_out("timeout", 8'h00, 3'd0, 1'b0, 1'b1);
    step(8'h20);
    check_out("regrant", 8'h20, 3'd5, 1'b1, 1'b0);
    step(8'h00);
    check_out("release5", 8'h00, 3'd0, 1'b0, 1'b0);

    // async reset between edges while 6 holds the grant
    step(8'h40);
    check_out("grant6", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h4A;
    #2 rst_n = 1'b0;
    #1 check_out("async_clear", 8'h00, 3'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_out("restart", 8'h02, 3'd1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
